// File: rtl/mac_decap.sv
// GMII receive decapsulator: strips preamble/SFD and FCS, streams DA..payload, flags bad frames.
// Build option MAC_DECAP_STATS_EN adds saturating good/bad/CRC-error frame counters.
module mac_decap #(
    parameter int MIN_FRAME_LENGTH = 64,
    parameter int MAX_FRAME_LENGTH = 1518
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rxdv,
    input  logic        gmii_rxer,
    input  logic        promiscuous,
    input  logic [47:0] mac_address,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic        rx_frame_good,
    output logic        rx_frame_bad
`ifdef MAC_DECAP_STATS_EN
    ,
    output logic [31:0] stat_good_frames,
    output logic [31:0] stat_bad_frames,
    output logic [31:0] stat_crc_errors
`endif
);

    localparam int          CW          = $clog2(MAX_FRAME_LENGTH + 2);
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_prev_dv;
    logic [CW-1:0] r_count;
    logic [31:0]   r_crc;
    logic [7:0]    r_sr [5];
    logic          r_err;
    logic          r_da_mac;
    logic          r_da_bcast;

    logic [7:0]    w_mac_byte [8];
    logic [31:0]   w_crc_next;
    logic          w_too_long;
    logic          w_end_bad;
    logic          w_sfd;
    logic          w_byte;
    logic          w_emit;
    logic          w_last;
    logic          w_user;
    logic          w_good;
    logic          w_bad;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Station address split into wire-order bytes, padded so a 3-bit count can index it.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mac_byte
            if (gi < 6) begin : g_addr
                assign w_mac_byte[gi] = mac_address[47 - 8*gi -: 8];
            end else begin : g_pad
                assign w_mac_byte[gi] = 8'h00;
            end
        end
    endgenerate

    assign w_crc_next = crc_byte(r_crc, gmii_rxd);
    assign w_too_long = (r_count >= CW'(MAX_FRAME_LENGTH));
    assign w_end_bad  = (r_crc != CRC_RESIDUE) | r_err
                      | (r_count < CW'(MIN_FRAME_LENGTH))
                      | ~(promiscuous | r_da_mac | r_da_bcast);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_sfd        = 1'b0;
        w_byte       = 1'b0;
        w_emit       = 1'b0;
        w_last       = 1'b0;
        w_user       = 1'b0;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        if (clk_enable) begin
            case (r_state)
                S_IDLE: begin
                    if (gmii_rxdv && !r_prev_dv && gmii_rxd == 8'h55)
                        w_state_next = S_PREAMBLE;
                end
                S_PREAMBLE: begin
                    if (!gmii_rxdv) begin
                        w_state_next = S_DROP;
                    end else if (gmii_rxd == 8'hD5) begin
                        w_state_next = S_DATA;
                        w_sfd        = 1'b1;
                    end else if (gmii_rxd != 8'h55) begin
                        w_state_next = S_DROP;
                    end
                end
                S_DATA: begin
                    if (gmii_rxdv) begin
                        if (w_too_long) begin
                            w_emit       = 1'b1;
                            w_last       = 1'b1;
                            w_user       = 1'b1;
                            w_bad        = 1'b1;
                            w_state_next = S_DROP;
                        end else begin
                            w_byte = 1'b1;
                            w_emit = (r_count >= CW'(5));
                        end
                    end else begin
                        w_state_next = S_IDLE;
                        // Frames of 4 bytes or less never filled the delay line: nothing to close.
                        if (r_count <= CW'(4)) begin
                            w_bad = 1'b1;
                        end else begin
                            w_emit = 1'b1;
                            w_last = 1'b1;
                            w_user = w_end_bad;
                            w_good = ~w_end_bad;
                            w_bad  = w_end_bad;
                        end
                    end
                end
                S_DROP: begin
                    if (!gmii_rxdv) w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_dv  <= 1'b1;
            r_count    <= '0;
            r_crc      <= '1;
            r_err      <= 1'b0;
            r_da_mac   <= 1'b0;
            r_da_bcast <= 1'b0;
            for (int i = 0; i < 5; i++) r_sr[i] <= '0;
        end else begin
            if (clk_enable) r_prev_dv <= gmii_rxdv;
            if (w_sfd) begin
                r_count    <= '0;
                r_crc      <= '1;
                r_err      <= gmii_rxer;
                r_da_mac   <= 1'b1;
                r_da_bcast <= 1'b1;
            end else if (w_byte) begin
                r_crc <= w_crc_next;
                if (r_count != '1) r_count <= r_count + 1'b1;
                r_err   <= r_err | gmii_rxer;
                r_sr[0] <= gmii_rxd;
                for (int i = 1; i < 5; i++) r_sr[i] <= r_sr[i-1];
                if (r_count < CW'(6)) begin
                    r_da_mac   <= r_da_mac & (gmii_rxd == w_mac_byte[r_count[2:0]]);
                    r_da_bcast <= r_da_bcast & (gmii_rxd == 8'hFF);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_tdata       <= '0;
            m_tvalid      <= 1'b0;
            m_tlast       <= 1'b0;
            m_tuser       <= 1'b0;
            rx_frame_good <= 1'b0;
            rx_frame_bad  <= 1'b0;
        end else begin
            m_tvalid      <= w_emit;
            m_tlast       <= w_last;
            m_tuser       <= w_user;
            rx_frame_good <= w_good;
            rx_frame_bad  <= w_bad;
            if (w_emit) m_tdata <= r_sr[4];
        end
    end

`ifdef MAC_DECAP_STATS_EN
    logic w_crc_fail;
    assign w_crc_fail = clk_enable && (r_state == S_DATA) && !gmii_rxdv && (r_crc != CRC_RESIDUE);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_good_frames <= '0;
            stat_bad_frames  <= '0;
            stat_crc_errors  <= '0;
        end else begin
            if (w_good && stat_good_frames != '1) stat_good_frames <= stat_good_frames + 1'b1;
            if (w_bad && stat_bad_frames != '1)   stat_bad_frames  <= stat_bad_frames + 1'b1;
            if (w_crc_fail && stat_crc_errors != '1) stat_crc_errors <= stat_crc_errors + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_decap.sv
// Bench for mac_decap: directed and randomized frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_mac_decap;
    localparam int          MIN_LEN = 64;
    localparam int          MAX_LEN = 1518;
    localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_enable = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        gmii_rxdv = 1'b0;
    logic        gmii_rxer = 1'b0;
    logic        promiscuous = 1'b0;
    logic [47:0] mac_address = 48'h02_00_00_00_00_02;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tuser, rx_frame_good, rx_frame_bad;
`ifdef MAC_DECAP_STATS_EN
    logic [31:0] stat_good_frames, stat_bad_frames, stat_crc_errors;
`endif

    always #4 clk = ~clk;

    mac_decap #(.MIN_FRAME_LENGTH(MIN_LEN), .MAX_FRAME_LENGTH(MAX_LEN)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .gmii_rxd(gmii_rxd), .gmii_rxdv(gmii_rxdv), .gmii_rxer(gmii_rxer),
        .promiscuous(promiscuous), .mac_address(mac_address),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .rx_frame_good(rx_frame_good), .rx_frame_bad(rx_frame_bad)
`ifdef MAC_DECAP_STATS_EN
        , .stat_good_frames(stat_good_frames), .stat_bad_frames(stat_bad_frames),
        .stat_crc_errors(stat_crc_errors)
`endif
    );

    int         n_cmp = 0;
    int         n_fail = 0;
    int         div = 1;
    int         er_idx = -1;
    logic [7:0] frm[$];
    logic [7:0] pre_q[$];

    logic [7:0] cap_q[$];
    int         cap_last_cnt = 0, cap_last_pos = 0, cnt_good = 0, cnt_bad = 0;
    logic       cap_user = 1'b0;

    logic [7:0] exp_q[$];
    int         exp_last, exp_good, exp_bad;
    logic       exp_user;

    always @(negedge clk) begin
        if (m_tvalid) cap_q.push_back(m_tdata);
        if (m_tlast) begin
            cap_last_cnt++;
            cap_last_pos = cap_q.size();
            cap_user     = m_tuser;
        end
        if (rx_frame_good) cnt_good++;
        if (rx_frame_bad)  cnt_bad++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic dv, input logic [7:0] d, input logic er);
        for (int i = 1; i < div; i++) begin
            @(negedge clk);
            clk_enable = 1'b0;
        end
        @(negedge clk);
        clk_enable = 1'b1;
        gmii_rxdv  = dv;
        gmii_rxd   = d;
        gmii_rxer  = er;
    endtask

    function automatic logic [31:0] fcs_of(input int len);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_frame(input logic [47:0] da, input int n, input bit good_fcs);
        logic [7:0]  hdr [14];
        logic [31:0] fcs;
        for (int i = 0; i < 6; i++)  hdr[i] = da[47 - 8*i -: 8];
        for (int i = 6; i < 12; i++) hdr[i] = 8'($urandom);
        hdr[12] = 8'h08;
        hdr[13] = 8'h00;
        frm.delete();
        if (n < 4) begin
            for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
        end else begin
            for (int i = 0; i < n - 4; i++) frm.push_back(i < 14 ? hdr[i] : 8'($urandom));
            fcs = fcs_of(n - 4);
            for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
            if (!good_fcs) frm[n-1] = frm[n-1] ^ 8'h01;
        end
    endtask

    // Expected stream: DA..payload minus FCS, frame-level verdict from the receive rules.
    task automatic run_model();
        int          n;
        logic [47:0] da;
        logic [31:0] fcs;
        logic        bad;
        n = frm.size();
        exp_q.delete();
        exp_last = 0; exp_good = 0; exp_bad = 0; exp_user = 1'b0;
        if (n <= 4) begin
            exp_bad = 1;
        end else if (n > MAX_LEN) begin
            for (int i = 0; i < MAX_LEN - 4; i++) exp_q.push_back(frm[i]);
            exp_last = 1; exp_user = 1'b1; exp_bad = 1;
        end else begin
            for (int i = 0; i < n - 4; i++) exp_q.push_back(frm[i]);
            fcs = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
            bad = (fcs_of(n - 4) != fcs) || (er_idx >= 0 && er_idx < n) || (n < MIN_LEN);
            if (n >= 6) begin
                da  = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
                bad = bad || (!promiscuous && da != mac_address && da != BCAST);
            end
            exp_last = 1; exp_user = bad; exp_good = bad ? 0 : 1; exp_bad = bad ? 1 : 0;
        end
    endtask

    task automatic clear_cap();
        cap_q.delete();
        cap_last_cnt = 0; cap_last_pos = 0; cap_user = 1'b0; cnt_good = 0; cnt_bad = 0;
    endtask

    task automatic send_frame();
        foreach (pre_q[i]) tick(1'b1, pre_q[i], 1'b0);
        foreach (frm[i])   tick(1'b1, frm[i], (i == er_idx));
        repeat (12) tick(1'b0, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic run_frame(input string tag);
        int bad_at;
        run_model();
        clear_cap();
        send_frame();
        bad_at = -1;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            if (bad_at < 0 && cap_q[i] !== exp_q[i]) bad_at = i;
        check({tag, ".len"},     64'(cap_q.size()), 64'(exp_q.size()));
        check({tag, ".data_at"}, 64'(bad_at),       64'(-1));
        check({tag, ".lastcnt"}, 64'(cap_last_cnt), 64'(exp_last));
        check({tag, ".lastpos"}, 64'(cap_last_pos), 64'(exp_last != 0 ? exp_q.size() : 0));
        check({tag, ".tuser"},   64'(cap_user),     64'(exp_user));
        check({tag, ".good"},    64'(cnt_good),     64'(exp_good));
        check({tag, ".bad"},     64'(cnt_bad),      64'(exp_bad));
        $display("frame %s: len=%0d bytes_out=%0d tuser=%0b good=%0d bad=%0d",
                 tag, frm.size(), cap_q.size(), cap_user, cnt_good, cnt_bad);
    endtask

    task automatic default_preamble();
        pre_q.delete();
        for (int i = 0; i < 7; i++) pre_q.push_back(8'h55);
        pre_q.push_back(8'hD5);
    endtask

    initial begin
        int          n;
        logic [47:0] da;
        default_preamble();
        clk_enable = 1'b1;
        repeat (3) @(negedge clk);
        check("reset.outs", 64'({m_tdata, m_tvalid, m_tlast, m_tuser, rx_frame_good, rx_frame_bad}), 64'(0));
        reset = 1'b0;
        repeat (4) tick(1'b0, 8'h00, 1'b0);

        build_frame(mac_address, 64, 1'b1);
        run_frame("good64");
        frm[63] = frm[63] ^ 8'h01;
        run_frame("crc_err");
`ifdef MAC_DECAP_STATS_EN
        check("stat.good", 64'(stat_good_frames), 64'(1));
        check("stat.bad",  64'(stat_bad_frames),  64'(1));
        check("stat.crc",  64'(stat_crc_errors),  64'(1));
`endif

        build_frame(48'h02_00_00_00_00_01, 64, 1'b1);
        run_frame("da_miss");
        promiscuous = 1'b1;
        run_frame("da_promisc");
        promiscuous = 1'b0;

        pre_q = {8'h55, 8'h55, 8'h54};
        build_frame(mac_address, 64, 1'b1);
        clear_cap();
        send_frame();
        check("badpre.len",  64'(cap_q.size()), 64'(0));
        check("badpre.good", 64'(cnt_good),     64'(0));
        $display("frame badpre: bytes_out=%0d good=%0d", cap_q.size(), cnt_good);
        default_preamble();

        build_frame(mac_address, 3, 1'b1);
        run_frame("runt3");
        build_frame(mac_address, 5, 1'b1);
        run_frame("len5");
        build_frame(mac_address, 63, 1'b1);
        run_frame("len63");

        build_frame(mac_address, 64, 1'b1);
        er_idx = 20;
        run_frame("rxer20");
        er_idx = -1;

        for (int k = 0; k < 8; k++) begin
            n = int'($urandom_range(130, 56));
            case ($urandom_range(2, 0))
                0:       da = mac_address;
                1:       da = BCAST;
                default: da = {16'h0200, 32'($urandom)};
            endcase
            promiscuous = 1'($urandom_range(1, 0));
            build_frame(da, n, $urandom_range(3, 0) != 0);
            er_idx = ($urandom_range(3, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
            run_frame($sformatf("rand%0d", k));
        end
        er_idx = -1;
        promiscuous = 1'b0;

        // Reset lands on data byte 30; the rest of that frame must be ignored.
        build_frame(mac_address, 64, 1'b1);
        clear_cap();
        foreach (pre_q[i]) tick(1'b1, pre_q[i], 1'b0);
        for (int i = 0; i < 30; i++) tick(1'b1, frm[i], 1'b0);
        tick(1'b1, frm[30], 1'b0);
        reset = 1'b1;
        tick(1'b1, frm[31], 1'b0);
        reset = 1'b0;
        check("rstmid.outs", 64'({m_tdata, m_tvalid, m_tlast, m_tuser, rx_frame_good, rx_frame_bad}), 64'(0));
        clear_cap();
        for (int i = 32; i < 64; i++) tick(1'b1, frm[i], 1'b0);
        repeat (12) tick(1'b0, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        check("rstmid.len",  64'(cap_q.size()), 64'(0));
        check("rstmid.good", 64'(cnt_good),     64'(0));
        check("rstmid.bad",  64'(cnt_bad),      64'(0));
`ifdef MAC_DECAP_STATS_EN
        check("rstmid.stat_good", 64'(stat_good_frames), 64'(0));
`endif
        $display("frame rstmid: bytes_out=%0d good=%0d bad=%0d", cap_q.size(), cnt_good, cnt_bad);
        build_frame(mac_address, 64, 1'b1);
        run_frame("after_rst");

        div = 10;
        build_frame(BCAST, 1518, 1'b1);
        run_frame("max1518");
        build_frame(BCAST, 1519, 1'b1);
        run_frame("over1519");
        div = 1;
        build_frame(mac_address, 64, 1'b1);
        run_frame("after_drop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
